bin_to_bcd_serial: RTL

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one iteration per clock.
- Sits directly upstream of the BCD-to-Excess-3 stage.
- Accepts one binary word per valid/ready handshake, then streams the resulting BCD digits one 4-bit digit at a time, most-significant first.
- Each emitted digit drives the 4-bit BCD input of the downstream Excess-3 stage.

---
 rtl/bin_to_bcd_serial_if.sv | 30 +++
 rtl/bin_to_bcd_serial.sv | 120 ++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_serial_if.sv
// Handshake bundle for the serial binary-to-BCD converter: one binary word
// in over in_valid/in_ready, BCD digits out over digit_valid/digit_ready.
interface bin_to_bcd_serial_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] in_bin;
    logic             digit_valid;
    logic             digit_ready;
    logic [3:0]       digit_out;
    logic [IDX_W-1:0] digit_idx;
    logic             digit_last;
    logic             busy;

    // Converter side.
    modport slave (
        input  in_valid, in_bin, digit_ready,
        output in_ready, digit_valid, digit_out, digit_idx, digit_last, busy
    );

    // Producer / consumer side.
    modport master (
        output in_valid, in_bin, digit_ready,
        input  in_ready, digit_valid, digit_out, digit_idx, digit_last, busy
    );
endinterface

// File: rtl/bin_to_bcd_serial.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one iteration per
// clock). Accepts a word in IDLE, runs BIN_W iterations in SHIFT, then
// streams DIGITS BCD digits most-significant first in EMIT. All outputs are
// decoded from registers only. Supported BIN_W range is 1..62.
module bin_to_bcd_serial #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    bin_to_bcd_serial_if.slave bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
    function automatic bit range_ok();
        longint p    = 1;
        longint maxv = (longint'(1) << BIN_W) - 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (p <= maxv) p = p * 10;
        end
        return p > maxv;
    endfunction

    if (BIN_W < 1 || BIN_W > 62 || DIGITS < 1 || !range_ok()) begin : g_param_check
        $error("bin_to_bcd_serial: DIGITS too small for BIN_W (need 10^DIGITS > 2^BIN_W-1)");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BCD_W-1:0] adj;
    logic [3:0]       dout;

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    // NOTE: every register is reset, not just the FSM state, so an aborted
    // conversion can never leak a stale digit after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and datapath update: accept, add-3/shift iterations, digit walk.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        adj     = bcd_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    bin_d   = bus.in_bin;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                end
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    idx_d   = IDX_W'(DIGITS - 1);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.digit_ready) begin
                    if (idx_q == '0) state_d = IDLE;
                    else             idx_d   = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the BCD digit addressed by the current digit index.
    always_comb begin
        dout = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) dout = bcd_q[4*i +: 4];
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.digit_valid = (state_q == EMIT);
    assign bus.digit_out   = (state_q == EMIT) ? dout : 4'd0;
    assign bus.digit_idx   = idx_q;
    assign bus.digit_last  = (state_q == EMIT) && (idx_q == '0);
endmodule
